// File: rtl/axis_rr_arb_4to1.sv
// Round-robin arbiter and handshake gate for a 4:1 AXI-stream mux.
// Grants one source at a time for at most MAX_BURST beats, with one idle bubble between grants.
module axis_rr_arb_4to1 #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [1:0] sel,
  input  logic       m_valid,
  output logic       m_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] grant,
  output logic       busy
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t          r_state;
  logic [1:0]      r_sel;
  logic [1:0]      r_last;
  logic [3:0]      r_grant;
  logic            r_busy;
  logic [CW-1:0]   r_beat_cnt;

  logic            w_hs;
  logic            w_release;
  logic            w_pick_valid;
  logic [1:0]      w_pick;

  assign w_hs      = m_valid & out_ready & r_busy;
  assign w_release = (w_hs && (r_beat_cnt == LAST_BEAT)) || !req[r_sel];

  // Scan from farthest to nearest offset so the source right after r_last wins.
  always_comb begin
    logic [1:0] idx;
    idx          = r_last;
    w_pick       = r_last;
    w_pick_valid = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      idx = r_last + 2'(k);
      if (req[idx]) begin
        w_pick       = idx;
        w_pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sel      <= 2'd0;
      r_last     <= 2'd3;
      r_grant    <= 4'd0;
      r_busy     <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_state    <= ST_GRANT;
            r_sel      <= w_pick;
            r_grant    <= 4'd1 << w_pick;
            r_busy     <= 1'b1;
            r_beat_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_grant    <= 4'd0;
            r_last     <= r_sel;
            r_beat_cnt <= '0;
          end else if (w_hs) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_grant <= 4'd0;
        end
      endcase
    end
  end

  assign sel       = r_sel;
  assign grant     = r_grant;
  assign busy      = r_busy;
  assign m_ready   = out_ready & r_busy;
  assign out_valid = m_valid & r_busy;

endmodule

// File: tb/tb_axis_rr_arb_4to1.sv
// Randomized bench for axis_rr_arb_4to1 against a behavioural round-robin model,
// run on two instances (MAX_BURST=4 and MAX_BURST=1) sharing the same stimulus.
module tb_axis_rr_arb_4to1;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       out_ready;

  logic [1:0] sel_a, sel_b;
  logic [3:0] grant_a, grant_b;
  logic       busy_a, busy_b;
  logic       m_ready_a, m_ready_b;
  logic       out_valid_a, out_valid_b;
  logic       m_valid_a, m_valid_b;

  // Mux emulation: the selected source's valid feeds back as m_valid.
  assign m_valid_a = req[sel_a];
  assign m_valid_b = req[sel_b];

  axis_rr_arb_4to1 #(.MAX_BURST(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .sel(sel_a), .m_valid(m_valid_a),
    .m_ready(m_ready_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .grant(grant_a), .busy(busy_a)
  );

  axis_rr_arb_4to1 #(.MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .sel(sel_b), .m_valid(m_valid_b),
    .m_ready(m_ready_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .grant(grant_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state per instance: owner = granted source, -1 when idle.
  int mb_lim [2] = '{4, 1};
  int owner  [2];
  int beats  [2];
  int last_s [2];
  int msel   [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_next(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic model_reset(input int i);
    owner[i]  = -1;
    beats[i]  = 0;
    last_s[i] = 3;
    msel[i]   = 0;
  endtask

  task automatic model_step(input int i, input logic rst, input logic [3:0] r, input logic ordy);
    int p;
    if (!rst) begin
      model_reset(i);
    end else if (owner[i] < 0) begin
      p = pick_next(r, last_s[i]);
      if (p >= 0) begin
        owner[i] = p;
        msel[i]  = p;
        beats[i] = 0;
        $display("grant inst=%0d src=%0d t=%0t", i, p, $time);
      end
    end else begin
      if (!r[owner[i]]) begin
        last_s[i] = owner[i];
        owner[i]  = -1;
        beats[i]  = 0;
      end else if (ordy) begin
        beats[i]++;
        if (beats[i] == mb_lim[i]) begin
          last_s[i] = owner[i];
          owner[i]  = -1;
          beats[i]  = 0;
        end
      end
    end
  endtask

  task automatic check_comb(input int i);
    logic ov, mr, bz;
    bz = (owner[i] >= 0);
    ov = bz && req[msel[i]];
    mr = bz && out_ready;
    if (i == 0) begin
      check_val("out_valid[mb4]", 32'(out_valid_a), 32'(ov));
      check_val("m_ready[mb4]",   32'(m_ready_a),   32'(mr));
    end else begin
      check_val("out_valid[mb1]", 32'(out_valid_b), 32'(ov));
      check_val("m_ready[mb1]",   32'(m_ready_b),   32'(mr));
    end
  endtask

  task automatic check_regs(input int i);
    logic [3:0] g;
    g = (owner[i] >= 0) ? 4'(1 << owner[i]) : 4'd0;
    if (i == 0) begin
      check_val("sel[mb4]",   32'(sel_a),   32'(msel[i]));
      check_val("grant[mb4]", 32'(grant_a), 32'(g));
      check_val("busy[mb4]",  32'(busy_a),  32'(owner[i] >= 0));
    end else begin
      check_val("sel[mb1]",   32'(sel_b),   32'(msel[i]));
      check_val("grant[mb1]", 32'(grant_b), 32'(g));
      check_val("busy[mb1]",  32'(busy_b),  32'(owner[i] >= 0));
    end
  endtask

  // One clock cycle: apply inputs, check gated handshake, advance model, check registers.
  task automatic run_cycle(input logic rst, input logic [3:0] r, input logic ordy);
    rst_n     = rst;
    req       = r;
    out_ready = ordy;
    #1;
    for (int i = 0; i < 2; i++) check_comb(i);
    for (int i = 0; i < 2; i++) model_step(i, rst, r, ordy);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) check_regs(i);
  endtask

  initial begin
    logic [3:0] r;
    logic       ordy;
    logic       rst;

    rst_n     = 1'b0;
    req       = 4'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) model_reset(i);
    for (int i = 0; i < 2; i++) check_regs(i);

    // Single steady requester: repeating bursts with one bubble.
    for (int c = 0; c < 20; c++) run_cycle(1'b1, 4'b0001, 1'b1);
    // All requesting: full rotation.
    for (int c = 0; c < 40; c++) run_cycle(1'b1, 4'b1111, 1'b1);
    // Backpressure mid-burst.
    run_cycle(1'b0, 4'b0101, 1'b1);
    for (int c = 0; c < 3; c++)  run_cycle(1'b1, 4'b0101, 1'b1);
    for (int c = 0; c < 5; c++)  run_cycle(1'b1, 4'b0101, 1'b0);
    for (int c = 0; c < 12; c++) run_cycle(1'b1, 4'b0101, 1'b1);
    // Source drops its request mid-burst.
    for (int c = 0; c < 3; c++)  run_cycle(1'b1, 4'b0110, 1'b1);
    for (int c = 0; c < 6; c++)  run_cycle(1'b1, 4'b0100, 1'b1);
    // Reset in the middle of a burst on source 3.
    for (int c = 0; c < 4; c++)  run_cycle(1'b1, 4'b1000, 1'b1);
    run_cycle(1'b0, 4'b1000, 1'b1);
    for (int c = 0; c < 6; c++)  run_cycle(1'b1, 4'b1001, 1'b1);
    // Alternating pair, exercises one-beat grants on the MAX_BURST=1 instance.
    for (int c = 0; c < 16; c++) run_cycle(1'b1, 4'b1010, 1'b1);

    // Random traffic with held requests, stalls and occasional reset.
    r = 4'($urandom);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) r = 4'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 99) != 0);
      run_cycle(rst, r, ordy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
